// File: rtl/ex_muldiv_pkg.sv
// Shared RV32M encodings: funct3 ops, M-unit FSM states, operand forward selects.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ex_muldiv_pkg;

  // funct3 encodings of the RV32M opcode space
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Forwarding-unit operand selects; 2'b11 is unused and falls back to the register file
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] mem,
                                          input logic [31:0] wb);
    logic [31:0] v;
    case (sel)
      FWD_MEM: v = mem;
      FWD_WB:  v = wb;
      default: v = rf;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// Restoring divider on magnitudes, 1 quotient bit per cycle, sign fixup on the outputs.
// Latency: 32 busy cycles after start; divide-by-zero / signed overflow bypass in 1 cycle.
// Backpressure: none; a new start overrides any op in progress.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_q, bypass_q, q_neg_q, r_neg_q;
  logic [4:0]  cnt_q;
  logic [31:0] q_q, r_q, d_q;

  logic        a_neg, b_neg, div0, ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, diff;

  assign a_neg  = is_signed & dividend[31];
  assign b_neg  = is_signed & divisor[31];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor  : divisor;
  assign div0   = (divisor == 32'd0);
  assign ovf    = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // Partial remainder never exceeds the divisor, so 33 bits hold the shifted trial value
  assign rem_sh = {r_q, q_q[31]};
  assign diff   = rem_sh - {1'b0, d_q};

  // Load on start (special cases resolve immediately), otherwise one restoring step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      bypass_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= 5'd0;
      q_q      <= 32'd0;
      r_q      <= 32'd0;
      d_q      <= 32'd0;
    end else if (start) begin
      busy_q <= 1'b1;
      d_q    <= b_mag;
      if (div0) begin
        bypass_q <= 1'b1;
        cnt_q    <= 5'd31;
        q_q      <= 32'hFFFF_FFFF;
        r_q      <= dividend;
        q_neg_q  <= 1'b0;
        r_neg_q  <= 1'b0;
      end else if (ovf) begin
        bypass_q <= 1'b1;
        cnt_q    <= 5'd31;
        q_q      <= 32'h8000_0000;
        r_q      <= 32'd0;
        q_neg_q  <= 1'b0;
        r_neg_q  <= 1'b0;
      end else begin
        bypass_q <= 1'b0;
        cnt_q    <= 5'd0;
        q_q      <= a_mag;
        r_q      <= 32'd0;
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
      end
    end else if (busy_q) begin
      if (!bypass_q) begin
        if (!diff[32]) begin
          r_q <= diff[31:0];
          q_q <= {q_q[30:0], 1'b1};
        end else begin
          r_q <= rem_sh[31:0];
          q_q <= {q_q[30:0], 1'b0};
        end
      end
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign last      = busy_q && (cnt_q == 5'd31);
  assign quotient  = q_neg_q ? -q_q : q_q;
  assign remainder = r_neg_q ? -r_q : r_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: operand forwarding mux, 2-cycle multiplier, iterative divider, control FSM.
// Latency: MUL* done at S+2, DIV/REM done at S+33 (S+2 for divide-by-zero / overflow).
// Backpressure: stall held high in the accept cycle and every busy cycle; flush aborts silently.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  funct3,
  input  logic [1:0]  forward1,
  input  logic [1:0]  forward2,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state_q, state_d;
  mdop_e       f3_q;
  logic [31:0] a_q, b_q, mul_q, result_q;

  logic        accept;
  logic [31:0] op_a, op_b;
  logic [32:0] a_ext, b_ext;
  logic [63:0] prod;
  logic [31:0] mul_res, div_res, final_res;
  logic        div_busy, div_last;
  logic [31:0] div_quo, div_rem;

  assign accept = !rst && (state_q == ST_IDLE) && valid_in && !flush;
  assign op_a   = fwd_sel(forward1, rs1_data, mem_fwd_data, wb_fwd_data);
  assign op_b   = fwd_sel(forward2, rs2_data, mem_fwd_data, wb_fwd_data);

  // 33x33 signed product; only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed
  assign a_ext   = {((f3_q == OP_MULH) || (f3_q == OP_MULHSU)) & a_q[31], a_q};
  assign b_ext   = {(f3_q == OP_MULH) & b_q[31], b_q};
  assign prod    = $signed(a_ext) * $signed(b_ext);
  assign mul_res = (f3_q == OP_MUL) ? prod[31:0] : prod[63:32];

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && funct3[2]),
    .is_signed (!funct3[0]),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_res   = f3_q[1] ? div_rem : div_quo;
  assign final_res = f3_q[2] ? div_res : mul_q;

  assign done   = !rst && (state_q == ST_DONE) && !flush;
  assign stall  = accept || (!rst && ((state_q == ST_MUL) || (state_q == ST_DIV)));
  assign result = rst ? 32'd0 : (done ? final_res : result_q);

  // Next-state: accept from IDLE, flush aborts to IDLE, DONE lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = funct3[2] ? ST_DIV : ST_MUL;
      ST_MUL:  state_d = flush ? ST_IDLE : ST_DONE;
      ST_DIV: begin
        if (flush)          state_d = ST_IDLE;
        else if (div_last)  state_d = ST_DONE;
        else if (!div_busy) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand/op latch at accept, product capture in MUL, result hold across ops
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q     <= OP_MUL;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mul_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      if (accept) begin
        f3_q <= mdop_e'(funct3);
        a_q  <= op_a;
        b_q  <= op_b;
      end
      if (state_q == ST_MUL) mul_q <= mul_res;
      if (done) result_q <= final_res;
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 valid_in  in  1  EX-stage instruction is an RV32M op.
REQ-004 funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 forward1, forward2  in  2  operand select: 00 register file, 01 EX/MEM, 10 MEM/WB, 11 treated as 00.
REQ-006 rs1_data, rs2_data  in  32  register-file operands from ID/EX.
REQ-007 mem_fwd_data, wb_fwd_data  in  32  EX/MEM and MEM/WB forwarding values.
REQ-008 flush  in  1  kill the in-flight op (branch or trap redirect).
REQ-009 stall  out  1  hold IF/ID/EX; the hazard logic ORs this into the pipeline freeze.
REQ-010 done  out  1  one-cycle pulse; result valid.
REQ-011 result  out  32  M-extension result; held until the next done.

Function
REQ-012 States: IDLE, MUL, DIV, DONE.
REQ-013 The operand mux is driven by forward1/forward2 and is sampled only in the accept cycle S, when valid_in=1, state=IDLE and flush=0.
REQ-014 In cycle S, the selected operands and funct3 shall be latched; later changes in the forwarding sources shall not affect the op.
REQ-015 stall shall be combinational and high in S and in every MUL/DIV cycle; it shall be low in DONE and in IDLE without an accept.
REQ-016 Multiply: IDLE->MUL at S; MUL->DONE at S+1; done=1 in cycle S+2.
REQ-017 Multiply uses a 33x33 signed product with sign-extension per funct3 (MULHSU: rs1 signed, rs2 unsigned); MUL returns bits[31:0], MULH* return bits[63:32].
REQ-018 Divide is a restoring, 1 bit per cycle, 32-iteration divider on magnitudes, followed by a sign fixup (quotient negated if the operand signs differ; remainder takes the dividend's sign).
REQ-019 Divide timing: IDLE->DIV at S; done=1 at S+33.
REQ-020 Divide by zero: quotient=0xFFFFFFFF, remainder=dividend; bypass iteration, done at S+2.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0; done at S+2.
REQ-022 DONE->IDLE unconditionally after one cycle.
REQ-023 A valid_in that arrives in DONE shall be ignored; the pipeline advances in DONE, so the next op is presented in IDLE.
REQ-024 flush in MUL, DIV or DONE: next state IDLE, no done pulse, result unchanged.
REQ-025 flush in IDLE overrides valid_in: no accept.
REQ-026 valid_in=0 in IDLE: no state change, stall=0.

Reset
REQ-027 While rst=1: state=IDLE, done=0, result=0, iteration counter=0, latched operands=0.
REQ-028 stall=0 whenever rst=1.
REQ-029 Reset mid-operation abandons the op without a done pulse.
REQ-030 rst has priority over flush and valid_in.

Structure
REQ-031 The funct3 op encodings, the state encoding and the forward-select codes (00/01/10) belong in a shared package, also used by the forwarding unit and the hazard unit.
REQ-032 The iterative divider shall be one sub-module, div_iter (start, signed flag, operands in; busy, quotient, remainder out).
REQ-033 The operand mux, multiplier and FSM stay in ex_muldiv.

Verification
REQ-034 MUL: rs1=7, rs2=-3, forward=00/00, valid at S -> stall in S and S+1; done at S+2; result=0xFFFFFFEB.
REQ-035 MULHU with forward1=01, mem_fwd_data=0xFFFFFFFF, rs2=0xFFFFFFFF; mem_fwd_data changed in S+1 -> result=0xFFFFFFFE.
REQ-036 DIV: -20/3 -> done at S+33, result=0xFFFFFFFA. REM: -20/3 -> result=0xFFFFFFFE (forward2=10, wb_fwd_data=3).
REQ-037 DIVU x/0 -> done at S+2, result=0xFFFFFFFF. DIV 0x80000000/-1 -> result=0x80000000. REM 0x80000000/-1 -> result=0.
REQ-038 flush at S+10 of a DIV -> state=IDLE at S+11; no done; stall low from S+11; a new MUL accepted at S+11 completes at S+13.
REQ-039 rst at S+5 of a DIV -> all outputs=0 next cycle; no done.
